// File: rtl/kbd_event_sequencer.sv
// kbd_event_sequencer
// Turns a stream of PS/2 set-2 scancode bytes into key events (release, press,
// typematic repeat). Prefix bytes (E0, F0, E0 F0) are tracked by the FSM, the
// Pause sequence (E1 + 7 bytes) is swallowed, and a 256-bit pressed bitmap
// distinguishes a fresh press from a repeat and filters orphan releases.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   byte_valid      receiver byte available
//   byte_data       received byte
//   byte_ready      byte accepted on byte_valid & byte_ready
//   scancode        registered {prefix, code} presented to the converter
//   evcode          converter result for scancode (combinational, external)
//   ev_valid        event available, held until ev_ready
//   ev_code         evdev key code
//   ev_value        0 release, 1 press, 2 repeat
//   ev_ready        event consumed on ev_valid & ev_ready
//   bat_pulse       one-cycle pulse on self-test pass byte AA
//   err_pulse       one-cycle pulse on error byte or mid-sequence timeout
module kbd_event_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter bit          REPEAT_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [15:0] scancode,
    input  logic [7:0]  evcode,
    output logic        ev_valid,
    output logic [7:0]  ev_code,
    output logic [1:0]  ev_value,
    input  logic        ev_ready,
    output logic        bat_pulse,
    output logic        err_pulse
);

    typedef enum logic [2:0] {
        StIdle,
        StE0,
        StF0,
        StE0F0,
        StPause,
        StLookup,
        StEmit
    } state_t;

    // Counter runs 0..TIMEOUT_CYCLES-1; reaching the last value with no byte
    // means TIMEOUT_CYCLES idle cycles have elapsed.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t         state;
    logic           brk;
    logic [2:0]     skip;
    logic [CW-1:0]  to_cnt;
    logic [255:0]   pressed;
    logic           accept;
    logic           mid_seq;

    // Ready is decoded from state but forced low while reset is held.
    assign byte_ready = !rst && (state inside {StIdle, StE0, StF0, StE0F0, StPause});
    assign accept     = byte_valid && byte_ready;
    assign mid_seq    = state inside {StE0, StF0, StE0F0, StPause};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            brk       <= 1'b0;
            skip      <= 3'd0;
            to_cnt    <= '0;
            pressed   <= '0;
            scancode  <= 16'h0000;
            ev_valid  <= 1'b0;
            ev_code   <= 8'h00;
            ev_value  <= 2'd0;
            bat_pulse <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            bat_pulse <= 1'b0;
            err_pulse <= 1'b0;

            // Timeout only while waiting inside a multi-byte sequence; any
            // accepted byte restarts it. Abort never collides with the case
            // below since that only moves state on an accepted byte.
            if (mid_seq && !accept) begin
                if (to_cnt == TO_LAST) begin
                    state     <= StIdle;
                    err_pulse <= 1'b1;
                    skip      <= 3'd0;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end

            case (state)
                StIdle: begin
                    if (accept) begin
                        case (byte_data)
                            8'hE0: state <= StE0;
                            8'hF0: state <= StF0;
                            8'hE1: begin
                                state <= StPause;
                                skip  <= 3'd7;
                            end
                            8'hFA, 8'hEE: ;  // ack / echo: nothing to report
                            8'hAA: begin
                                bat_pulse <= 1'b1;
                                pressed   <= '0;
                            end
                            8'h00, 8'hFF, 8'hFE: err_pulse <= 1'b1;
                            default: begin
                                scancode <= {8'h00, byte_data};
                                brk      <= 1'b0;
                                state    <= StLookup;
                            end
                        endcase
                    end
                end
                StE0: begin
                    if (accept) begin
                        if (byte_data == 8'hF0) begin
                            state <= StE0F0;
                        end else if (byte_data == 8'h12) begin
                            state <= StIdle;  // fake shift
                        end else begin
                            scancode <= {8'hE0, byte_data};
                            brk      <= 1'b0;
                            state    <= StLookup;
                        end
                    end
                end
                StF0: begin
                    if (accept) begin
                        scancode <= {8'h00, byte_data};
                        brk      <= 1'b1;
                        state    <= StLookup;
                    end
                end
                StE0F0: begin
                    if (accept) begin
                        if (byte_data == 8'h12) begin
                            state <= StIdle;
                        end else begin
                            scancode <= {8'hE0, byte_data};
                            brk      <= 1'b1;
                            state    <= StLookup;
                        end
                    end
                end
                StPause: begin
                    if (accept) begin
                        if (skip == 3'd1) begin
                            skip  <= 3'd0;
                            state <= StIdle;
                        end else begin
                            skip <= skip - 3'd1;
                        end
                    end
                end
                StLookup: begin
                    // evcode is the converter's view of the scancode loaded last cycle.
                    if (brk) begin
                        if (pressed[evcode]) begin
                            pressed[evcode] <= 1'b0;
                            ev_code         <= evcode;
                            ev_value        <= 2'd0;
                            ev_valid        <= 1'b1;
                            state           <= StEmit;
                        end else begin
                            state <= StIdle;
                        end
                    end else if (!pressed[evcode]) begin
                        pressed[evcode] <= 1'b1;
                        ev_code         <= evcode;
                        ev_value        <= 2'd1;
                        ev_valid        <= 1'b1;
                        state           <= StEmit;
                    end else if (REPEAT_EN) begin
                        ev_code  <= evcode;
                        ev_value <= 2'd2;
                        ev_valid <= 1'b1;
                        state    <= StEmit;
                    end else begin
                        state <= StIdle;
                    end
                end
                StEmit: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_event_sequencer.sv
module tb_kbd_event_sequencer;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        ev_ready;

    logic        byte_ready, ev_valid, bat_pulse, err_pulse;
    logic [15:0] scancode;
    logic [7:0]  evcode, ev_code;
    logic [1:0]  ev_value;

    logic        nr_byte_ready, nr_ev_valid, nr_bat_pulse, nr_err_pulse;
    logic [15:0] nr_scancode;
    logic [7:0]  nr_evcode, nr_ev_code;
    logic [1:0]  nr_ev_value;

    int total = 0;
    int bad = 0;
    int ready_waits = 0;
    int valid_cycles = 0;
    int err_cycles = 0;
    int bat_cycles = 0;

    bit         found;
    logic [7:0] code;
    logic [1:0] value;

    always #5 clk = ~clk;

    // Converter model: a few known scancodes, everything else maps to 0.
    function automatic logic [7:0] conv(input logic [15:0] s);
        case (s)
            16'h001C: conv = 8'd30;
            16'hE075: conv = 8'd103;
            16'h0014: conv = 8'd29;
            16'h0077: conv = 8'd69;
            default:  conv = 8'd0;
        endcase
    endfunction

    assign evcode    = conv(scancode);
    assign nr_evcode = conv(nr_scancode);

    kbd_event_sequencer #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .scancode(scancode), .evcode(evcode),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_value(ev_value),
        .ev_ready(ev_ready), .bat_pulse(bat_pulse), .err_pulse(err_pulse)
    );

    kbd_event_sequencer #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(nr_byte_ready), .scancode(nr_scancode), .evcode(nr_evcode),
        .ev_valid(nr_ev_valid), .ev_code(nr_ev_code), .ev_value(nr_ev_value),
        .ev_ready(ev_ready), .bat_pulse(nr_bat_pulse), .err_pulse(nr_err_pulse)
    );

    always @(posedge clk) begin
        if (ev_valid)  valid_cycles <= valid_cycles + 1;
        if (err_pulse) err_cycles   <= err_cycles + 1;
        if (bat_pulse) bat_cycles   <= bat_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Returns #1 after the accepting clock edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ready_waits += n;
        total++;
        if (!byte_ready) begin
            bad++;
            $display("FAIL send_byte %h: byte_ready=%b after %0d cycles, required 1", b,
                     byte_ready, n);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Waits (bounded) for an event, captures it and completes the handshake.
    task automatic take_event();
        found = 1'b0;
        code  = 8'h00;
        value = 2'd0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ev_valid) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (found) begin
            code     = ev_code;
            value    = ev_value;
            ev_ready = 1'b1;
            @(posedge clk);
            #1;
            ev_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        ev_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        ev_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (byte_ready !== 1'b0 || ev_valid !== 1'b0 || scancode !== 16'h0000 ||
            ev_code !== 8'h00 || ev_value !== 2'd0 || bat_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b sc=%h code=%h val=%0d bat=%b err=%b, required all 0",
                     byte_ready, ev_valid, scancode, ev_code, ev_value, bat_pulse, err_pulse);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b required 1", byte_ready);
        end
    endtask

    task automatic test_make_break();
        do_reset();
        send_byte(8'h1C);
        total++;
        if (scancode !== 16'h001C || ev_valid !== 1'b0) begin
            bad++;
            $display("FAIL make_accept: scancode=%h vld=%b, required 001C 0", scancode, ev_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (ev_valid !== 1'b1 || ev_code !== 8'd30 || ev_value !== 2'd1) begin
            bad++;
            $display("FAIL make_latency: vld=%b code=%0d val=%0d, required 1 30 1",
                     ev_valid, ev_code, ev_value);
        end
        take_event();
        total++;
        if (ev_valid !== 1'b0 || byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL make_handshake: vld=%b rdy=%b, required 0 1", ev_valid, byte_ready);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd30 || value !== 2'd0) begin
            bad++;
            $display("FAIL break_1c: found=%b code=%0d val=%0d, required 1 30 0", found, code, value);
        end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        total++;
        if (scancode !== 16'hE075) begin
            bad++;
            $display("FAIL ext_scancode: got %h required E075", scancode);
        end
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd103 || value !== 2'd1) begin
            bad++;
            $display("FAIL ext_make: found=%b code=%0d val=%0d, required 1 103 1", found, code, value);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd103 || value !== 2'd0) begin
            bad++;
            $display("FAIL ext_break: found=%b code=%0d val=%0d, required 1 103 0", found, code, value);
        end
    endtask

    task automatic test_repeat();
        bit nr_seen = 1'b0;
        do_reset();
        send_byte(8'h1C);
        @(posedge clk);
        #1;
        total++;
        if (nr_ev_valid !== 1'b1 || nr_ev_code !== 8'd30 || nr_ev_value !== 2'd1) begin
            bad++;
            $display("FAIL norep_first: vld=%b code=%0d val=%0d, required 1 30 1",
                     nr_ev_valid, nr_ev_code, nr_ev_value);
        end
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd30 || value !== 2'd1) begin
            bad++;
            $display("FAIL rep_first: found=%b code=%0d val=%0d, required 1 30 1", found, code, value);
        end
        send_byte(8'h1C);
        for (int i = 0; i < 4; i++) begin
            nr_seen |= nr_ev_valid;
            @(posedge clk);
            #1;
        end
        total++;
        if (nr_seen !== 1'b0) begin
            bad++;
            $display("FAIL norep_second: ev_valid seen=%b required 0", nr_seen);
        end
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd30 || value !== 2'd2) begin
            bad++;
            $display("FAIL rep_second: found=%b code=%0d val=%0d, required 1 30 2", found, code, value);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        int v0, w0;
        do_reset();
        v0 = valid_cycles;
        w0 = ready_waits;
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (valid_cycles != v0 || ready_waits != w0) begin
            bad++;
            $display("FAIL pause_silent: valid cycles=%0d stalls=%0d, required 0 0",
                     valid_cycles - v0, ready_waits - w0);
        end
        send_byte(8'h1C);
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd30 || value !== 2'd1) begin
            bad++;
            $display("FAIL pause_after: found=%b code=%0d val=%0d, required 1 30 1", found, code, value);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int e0, v0;
        do_reset();
        e0 = err_cycles;
        v0 = valid_cycles;
        send_byte(8'hF0);
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (err_pulse) break;
        end
        total++;
        if (n != TO) begin
            bad++;
            $display("FAIL timeout_cycles: err_pulse after %0d cycles, required %0d", n, TO);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (err_cycles - e0 != 1 || valid_cycles != v0) begin
            bad++;
            $display("FAIL timeout_once: err cycles=%0d events=%0d, required 1 0",
                     err_cycles - e0, valid_cycles - v0);
        end
        send_byte(8'h1C);
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd30 || value !== 2'd1) begin
            bad++;
            $display("FAIL timeout_after: found=%b code=%0d val=%0d, required 1 30 1", found, code, value);
        end
    endtask

    task automatic test_backpressure();
        bit stable = 1'b1;
        int e0, v0;
        do_reset();
        e0 = err_cycles;
        send_byte(8'h1C);
        @(posedge clk);
        #1;
        // Held longer than the timeout to show a stalled consumer never aborts.
        for (int i = 0; i < 30; i++) begin
            if (ev_valid !== 1'b1 || ev_code !== 8'd30 || ev_value !== 2'd1 || byte_ready !== 1'b0)
                stable = 1'b0;
            @(posedge clk);
            #1;
        end
        total++;
        if (stable !== 1'b1 || err_cycles != e0) begin
            bad++;
            $display("FAIL bp_hold: stable=%b err cycles=%0d, required 1 0", stable, err_cycles - e0);
        end
        take_event();
        send_byte(8'hAA);
        total++;
        if (bat_pulse !== 1'b1 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL bat_pulse: bat=%b err=%b, required 1 0", bat_pulse, err_pulse);
        end
        v0 = valid_cycles;
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (valid_cycles != v0) begin
            bad++;
            $display("FAIL bat_clears_bitmap: event cycles=%0d, required 0", valid_cycles - v0);
        end
    endtask

    task automatic test_special_bytes();
        int v0, b0;
        do_reset();
        send_byte(8'h1C);
        take_event();
        v0 = valid_cycles;
        b0 = bat_cycles;
        send_byte(8'hFA);
        send_byte(8'hEE);
        send_byte(8'hE0);
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'hFF);
        total++;
        if (err_pulse !== 1'b1 || bat_pulse !== 1'b0) begin
            bad++;
            $display("FAIL err_byte: err=%b bat=%b, required 1 0", err_pulse, bat_pulse);
        end
        @(posedge clk);
        #1;
        total++;
        if (err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL err_single: err=%b on second cycle, required 0", err_pulse);
        end
        total++;
        if (valid_cycles != v0 || bat_cycles != b0 || scancode !== 16'h001C) begin
            bad++;
            $display("FAIL dropped_bytes: events=%0d bats=%0d scancode=%h, required 0 0 001C",
                     valid_cycles - v0, bat_cycles - b0, scancode);
        end
    endtask

    task automatic test_reset_in_emit();
        do_reset();
        send_byte(8'h1C);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (ev_valid !== 1'b0 || byte_ready !== 1'b0 || scancode !== 16'h0000) begin
            bad++;
            $display("FAIL reset_emit: vld=%b rdy=%b sc=%h, required 0 0 0000",
                     ev_valid, byte_ready, scancode);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'h1C);
        take_event();
        total++;
        if (found !== 1'b1 || code !== 8'd30 || value !== 2'd1) begin
            bad++;
            $display("FAIL reset_emit_after: found=%b code=%0d val=%0d, required 1 30 1",
                     found, code, value);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_repeat();
        test_pause();
        test_timeout();
        test_backpressure();
        test_special_bytes();
        test_reset_in_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
